// File: rtl/sdram_arbiter.sv
// sdram_arbiter: slot-based three-port SDRAM arbiter (video word reads,
// boot-loader byte writes, CPU byte reads/writes). One access per clkref
// slot. Fixed priority video > boot > cpu.
// Optional macro ARB_STARVE_EN: after two consecutive lost slots the CPU
// is forced to win the next slot. Undefined: strict priority.
`timescale 1ns/1ps
module sdram_arbiter #(
    parameter int SD_LAT = 8,
    parameter int ADDR_W = 23
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              clkref,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [15:0]       vid_data,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic              cpu_ack,
    output logic [7:0]        cpu_dout,
    input  logic              boot_wr,
    input  logic [ADDR_W-1:0] boot_addr,
    input  logic [7:0]        boot_din,
    output logic              boot_ack,
    output logic              sd_oe,
    output logic              sd_we,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [7:0]        sd_din,
    input  logic [7:0]        sd_dout,
    input  logic [15:0]       sd_vdout,
    output logic              sd_vid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SRC_VID  = 2'd0,
        SRC_BOOT = 2'd1,
        SRC_CPU  = 2'd2
    } src_t;

    state_t            state_q, state_d;
    src_t              src_q, src_d;
    logic              wr_q, wr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              sd_oe_q, sd_oe_d;
    logic              sd_we_q, sd_we_d;
    logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
    logic [7:0]        sd_din_q, sd_din_d;
    logic              sd_vid_q, sd_vid_d;
    logic              vid_ack_q, vid_ack_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              boot_ack_q, boot_ack_d;
    logic [15:0]       vid_data_q, vid_data_d;
    logic [7:0]        cpu_dout_q, cpu_dout_d;

    // A requester whose ack is showing this cycle still holds its request
    // level; it must not be granted a second time on that stale level.
    logic vid_act_s, boot_act_s, cpu_act_s, any_req_s, grant_s;
    logic cnt_last_s, win_wr_s, starve_force_s;
    src_t win_s;

    assign vid_act_s  = vid_req & ~vid_ack_q;
    assign boot_act_s = boot_wr & ~boot_ack_q;
    assign cpu_act_s  = (cpu_rd | cpu_wr) & ~cpu_ack_q;
    assign any_req_s  = vid_act_s | boot_act_s | cpu_act_s;
    assign grant_s    = (state_q == ST_IDLE) & clkref & any_req_s;
    assign cnt_last_s = (cnt_q == 4'(SD_LAT - 2));

`ifdef ARB_STARVE_EN
    logic [1:0] starve_q, starve_d;
    assign starve_force_s = cpu_act_s & (starve_q == 2'd2);
`else
    assign starve_force_s = 1'b0;
`endif

    // Pick the slot winner: starvation override first, then fixed priority.
    always_comb begin
        win_s = SRC_CPU;
        if (starve_force_s) begin
            win_s = SRC_CPU;
        end else if (vid_act_s) begin
            win_s = SRC_VID;
        end else if (boot_act_s) begin
            win_s = SRC_BOOT;
        end else begin
            win_s = SRC_CPU;
        end
    end

    // Write/read decision for the winner; rd+wr together counts as a write.
    always_comb begin
        win_wr_s = 1'b0;
        case (win_s)
            SRC_BOOT: win_wr_s = 1'b1;
            SRC_CPU:  win_wr_s = cpu_wr;
            default:  win_wr_s = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d = ST_CMD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (cnt_last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; command strobes are set on the grant edge
    // so they are high exactly during the CMD cycle.
    always_comb begin
        sd_oe_d    = 1'b0;
        sd_we_d    = 1'b0;
        vid_ack_d  = 1'b0;
        cpu_ack_d  = 1'b0;
        boot_ack_d = 1'b0;
        sd_addr_d  = sd_addr_q;
        sd_din_d   = sd_din_q;
        sd_vid_d   = sd_vid_q;
        src_d      = src_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;
        vid_data_d = vid_data_q;
        cpu_dout_d = cpu_dout_q;
`ifdef ARB_STARVE_EN
        starve_d   = starve_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    sd_oe_d  = ~win_wr_s;
                    sd_we_d  = win_wr_s;
                    src_d    = win_s;
                    wr_d     = win_wr_s;
                    sd_vid_d = (win_s == SRC_VID);
                    case (win_s)
                        SRC_VID: begin
                            sd_addr_d = vid_addr;
                            sd_din_d  = 8'h00;
                        end
                        SRC_BOOT: begin
                            sd_addr_d = boot_addr;
                            sd_din_d  = boot_din;
                        end
                        SRC_CPU: begin
                            sd_addr_d = cpu_addr;
                            sd_din_d  = cpu_din;
                        end
                        default: begin
                            sd_addr_d = sd_addr_q;
                            sd_din_d  = sd_din_q;
                        end
                    endcase
`ifdef ARB_STARVE_EN
                    if (win_s == SRC_CPU) begin
                        starve_d = 2'd0;
                    end else if (cpu_act_s) begin
                        starve_d = starve_q + 2'd1;
                    end else begin
                        starve_d = 2'd0;
                    end
`endif
                end else begin
                    cnt_d = 4'd0;
                end
            end
            ST_CMD:  cnt_d = 4'd0;
            ST_WAIT: cnt_d = cnt_q + 4'd1;
            ST_DONE: begin
                case (src_q)
                    SRC_VID: begin
                        vid_ack_d = 1'b1;
                        if (!wr_q) begin
                            vid_data_d = sd_vdout;
                        end else begin
                            vid_data_d = vid_data_q;
                        end
                    end
                    SRC_BOOT: boot_ack_d = 1'b1;
                    SRC_CPU: begin
                        cpu_ack_d = 1'b1;
                        if (!wr_q) begin
                            cpu_dout_d = sd_dout;
                        end else begin
                            cpu_dout_d = cpu_dout_q;
                        end
                    end
                    default: cpu_ack_d = 1'b0;
                endcase
            end
            default: cnt_d = 4'd0;
        endcase
    end

    // Datapath and output registers; reset aborts any access in flight.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            src_q      <= SRC_VID;
            wr_q       <= 1'b0;
            cnt_q      <= 4'd0;
            sd_oe_q    <= 1'b0;
            sd_we_q    <= 1'b0;
            sd_addr_q  <= '0;
            sd_din_q   <= 8'h00;
            sd_vid_q   <= 1'b0;
            vid_ack_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            boot_ack_q <= 1'b0;
            vid_data_q <= 16'h0000;
            cpu_dout_q <= 8'h00;
`ifdef ARB_STARVE_EN
            starve_q   <= 2'd0;
`endif
        end else begin
            src_q      <= src_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            sd_oe_q    <= sd_oe_d;
            sd_we_q    <= sd_we_d;
            sd_addr_q  <= sd_addr_d;
            sd_din_q   <= sd_din_d;
            sd_vid_q   <= sd_vid_d;
            vid_ack_q  <= vid_ack_d;
            cpu_ack_q  <= cpu_ack_d;
            boot_ack_q <= boot_ack_d;
            vid_data_q <= vid_data_d;
            cpu_dout_q <= cpu_dout_d;
`ifdef ARB_STARVE_EN
            starve_q   <= starve_d;
`endif
        end
    end

    assign sd_oe    = sd_oe_q;
    assign sd_we    = sd_we_q;
    assign sd_addr  = sd_addr_q;
    assign sd_din   = sd_din_q;
    assign sd_vid   = sd_vid_q;
    assign vid_ack  = vid_ack_q;
    assign cpu_ack  = cpu_ack_q;
    assign boot_ack = boot_ack_q;
    assign vid_data = vid_data_q;
    assign cpu_dout = cpu_dout_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Testbench for sdram_arbiter: random requesters checked every cycle against
// a slot/transaction-level reference model, plus directed scenarios.
`timescale 1ns/1ps
module tb_sdram_arbiter;
    localparam int SD_LAT = 8;
    localparam int AW     = 23;
    localparam int P_NONE = 0;
    localparam int P_VID  = 1;
    localparam int P_BOOT = 2;
    localparam int P_CPU  = 3;

    logic          clk_sys, reset_n, clkref;
    logic          vid_req, vid_ack;
    logic [AW-1:0] vid_addr;
    logic [15:0]   vid_data;
    logic          cpu_rd, cpu_wr, cpu_ack;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din, cpu_dout;
    logic          boot_wr, boot_ack;
    logic [AW-1:0] boot_addr;
    logic [7:0]    boot_din;
    logic          sd_oe, sd_we, sd_vid;
    logic [AW-1:0] sd_addr;
    logic [7:0]    sd_din, sd_dout;
    logic [15:0]   sd_vdout;

    sdram_arbiter #(.SD_LAT(SD_LAT), .ADDR_W(AW)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .clkref(clkref),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .boot_wr(boot_wr), .boot_addr(boot_addr), .boot_din(boot_din), .boot_ack(boot_ack),
        .sd_oe(sd_oe), .sd_we(sd_we), .sd_addr(sd_addr), .sd_din(sd_din),
        .sd_dout(sd_dout), .sd_vdout(sd_vdout), .sd_vid(sd_vid)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // reference model: one transaction at a time, timed from its grant cycle
    bit            m_busy, m_wr, m_vid, m_cmd;
    int            m_g, m_src, m_ack, m_ack_last, m_starve;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_din, m_cdout;
    logic [15:0]   m_vdata;

    // requester agents
    bit            a_pend [4];
    logic [AW-1:0] a_addr [4];
    logic [7:0]    a_din  [4];
    int            prob   [4];
    int            cpu_kind;  // 0 read, 1 write, 2 rd+wr
    bit            rand_en, vid_cont, force_a5, rst_arm, rand_rst;
    int            bs_left, cr_mode, cr_cnt, rst_hold;
    logic [AW-1:0] bs_addr;
    int            cnt_cpu_ack, cnt_boot_ack, oe_cyc, ack_cyc, boot_first, boot_last;

    task automatic model_reset();
        m_busy = 1'b0; m_wr = 1'b0; m_vid = 1'b0; m_cmd = 1'b0;
        m_g = 0; m_src = P_NONE; m_ack = P_NONE; m_starve = 0;
        m_addr = '0; m_din = 8'h00; m_cdout = 8'h00; m_vdata = 16'h0000;
    endtask

    // Called at each rising edge, while inputs still hold the ended cycle's values.
    task automatic model_edge();
        int cur, ack_cur, win;
        bit rv, rb, rc;
        cur = cyc;
        ack_cur = m_ack;
        m_ack_last = m_ack;
        m_ack = P_NONE;
        m_cmd = 1'b0;
        if (!reset_n) begin
            model_reset();
        end else if (m_busy) begin
            if (cur == m_g + SD_LAT + 1) begin
                if (!m_wr && m_src == P_VID) m_vdata = sd_vdout;
                if (!m_wr && m_src == P_CPU) m_cdout = sd_dout;
                m_ack = m_src;
                m_busy = 1'b0;
            end
        end else if (clkref) begin
            rv = vid_req && ack_cur != P_VID;
            rb = boot_wr && ack_cur != P_BOOT;
            rc = (cpu_rd || cpu_wr) && ack_cur != P_CPU;
            if (rv || rb || rc) begin
                win = P_CPU;
                if (rv) win = P_VID;
                else if (rb) win = P_BOOT;
`ifdef ARB_STARVE_EN
                if (rc && m_starve >= 2) win = P_CPU;
                if (win == P_CPU) m_starve = 0;
                else if (rc) m_starve = m_starve + 1;
                else m_starve = 0;
`endif
                m_busy = 1'b1; m_cmd = 1'b1; m_g = cur; m_src = win;
                m_vid  = (win == P_VID);
                m_wr   = (win == P_BOOT) || (win == P_CPU && cpu_wr);
                if (win == P_VID) begin m_addr = vid_addr; m_din = 8'h00; end
                else if (win == P_BOOT) begin m_addr = boot_addr; m_din = boot_din; end
                else begin m_addr = cpu_addr; m_din = cpu_din; end
            end
        end
    endtask

    task automatic start_req(input int p);
        a_pend[p] = 1'b1;
        a_addr[p] = AW'($urandom);
        a_din[p]  = 8'($urandom);
        if (p == P_CPU) cpu_kind = int'($urandom_range(2, 0));
    endtask

    task automatic agents_update();
        for (int p = 1; p <= 3; p++) if (m_ack_last == p) a_pend[p] = 1'b0;
        if (vid_cont && !a_pend[P_VID]) start_req(P_VID);
        if (bs_left > 0 && !a_pend[P_BOOT]) begin
            a_pend[P_BOOT] = 1'b1; a_addr[P_BOOT] = bs_addr; a_din[P_BOOT] = 8'($urandom);
            bs_addr = bs_addr + 1'b1; bs_left--;
        end
        if (rand_en) begin
            for (int p = 1; p <= 3; p++) begin
                if (!a_pend[p]) begin
                    if (int'($urandom_range(99, 0)) < prob[p]) start_req(p);
                end else if (!(m_busy && m_src == p) && m_ack != p && $urandom_range(199, 0) == 0) begin
                    a_pend[p] = 1'b0;  // withdraw an ungranted request
                end
            end
        end
    endtask

    task automatic drive_inputs();
        if (cr_mode == 0) begin
            clkref = (cyc % 16 == 0);
        end else if (cr_cnt == 0) begin
            clkref = 1'b1; cr_cnt = int'($urandom_range(20, 3));
        end else begin
            clkref = 1'b0; cr_cnt--;
        end
        vid_req = a_pend[P_VID];   vid_addr = a_addr[P_VID];
        boot_wr = a_pend[P_BOOT];  boot_addr = a_addr[P_BOOT]; boot_din = a_din[P_BOOT];
        cpu_rd = a_pend[P_CPU] && cpu_kind != 1;
        cpu_wr = a_pend[P_CPU] && cpu_kind != 0;
        cpu_addr = a_addr[P_CPU];  cpu_din = a_din[P_CPU];
        sd_dout  = force_a5 ? 8'hA5 : 8'($urandom);
        sd_vdout = 16'($urandom);
    endtask

    task automatic check_cycle();
        check_eq("ctrl", 32'({sd_oe, sd_we, sd_vid, vid_ack, boot_ack, cpu_ack}),
                 32'({m_cmd && !m_wr, m_cmd && m_wr, m_vid,
                      m_ack == P_VID, m_ack == P_BOOT, m_ack == P_CPU}));
        check_eq("sd_addr", 32'(sd_addr), 32'(m_addr));
        check_eq("sd_din", 32'(sd_din), 32'(m_din));
        check_eq("vid_data", 32'(vid_data), 32'(m_vdata));
        check_eq("cpu_dout", 32'(cpu_dout), 32'(m_cdout));
    endtask

    task automatic run_cycle();
        @(posedge clk_sys);
        model_edge();
        cyc++;
        #1;
        agents_update();
        drive_inputs();
        if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) begin #1; reset_n = 1'b1; end
        end else if ((rst_arm && m_busy && cyc == m_g + 4) ||
                     (rand_rst && $urandom_range(599, 0) == 0)) begin
            #1;
            reset_n = 1'b0;
            model_reset();
            rst_arm = 1'b0;
            rst_hold = 3;
        end
        @(negedge clk_sys);
        check_cycle();
        if (cpu_ack) begin cnt_cpu_ack++; ack_cyc = cyc; end
        if (boot_ack) begin
            if (cnt_boot_ack == 0) boot_first = cyc;
            boot_last = cyc;
            cnt_boot_ack++;
        end
        if (sd_oe && oe_cyc < 0) oe_cyc = cyc;
    endtask

    initial begin
        reset_n = 1'b0; clkref = 1'b0;
        vid_req = 1'b0; vid_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_din = 8'h00;
        boot_wr = 1'b0; boot_addr = '0; boot_din = 8'h00; sd_dout = 8'h00; sd_vdout = 16'h0000;
        for (int p = 0; p < 4; p++) begin a_pend[p] = 1'b0; a_addr[p] = '0; a_din[p] = 8'h00; prob[p] = 0; end
        cpu_kind = 0; rand_en = 0; vid_cont = 0; force_a5 = 0; rst_arm = 0; rand_rst = 0;
        bs_left = 0; bs_addr = '0; cr_mode = 0; cr_cnt = 0; rst_hold = 3;
        cnt_cpu_ack = 0; cnt_boot_ack = 0; oe_cyc = -1; ack_cyc = -1; boot_first = 0; boot_last = 0;
        m_ack_last = P_NONE;
        model_reset();

        // reset state, then a single CPU read with known SDRAM data
        repeat (20) run_cycle();
        while (cyc % 16 != 2) run_cycle();
        force_a5 = 1'b1;
        a_pend[P_CPU] = 1'b1; a_addr[P_CPU] = 23'h000100; a_din[P_CPU] = 8'h3C; cpu_kind = 0;
        oe_cyc = -1; ack_cyc = -1; cnt_cpu_ack = 0;
        repeat (40) run_cycle();
        check_eq("rd_oe_slot", 32'(oe_cyc % 16), 32'd1);
        check_eq("rd_latency", 32'(ack_cyc - oe_cyc), 32'(SD_LAT + 1));
        check_eq("rd_data", 32'(cpu_dout), 32'h0000_00A5);
        check_eq("rd_ack_count", 32'(cnt_cpu_ack), 32'd1);
        force_a5 = 1'b0;

        // reset during WAIT of a CPU read: aborted, then completes after release
        while (cyc % 16 != 2) run_cycle();
        a_pend[P_CPU] = 1'b1; a_addr[P_CPU] = 23'h000200; cpu_kind = 0;
        rst_arm = 1'b1; cnt_cpu_ack = 0;
        repeat (30) run_cycle();
        check_eq("rst_no_ack", 32'(cnt_cpu_ack), 32'd0);
        repeat (30) run_cycle();
        check_eq("rst_resume", 32'(cnt_cpu_ack), 32'd1);

        // random traffic, regular slots
        rand_en = 1'b1; prob[P_VID] = 10; prob[P_BOOT] = 5; prob[P_CPU] = 10;
        repeat (3000) run_cycle();

        // random traffic, irregular clkref (some during busy), random resets
        cr_mode = 1; rand_rst = 1'b1;
        repeat (3000) run_cycle();
        rand_rst = 1'b0;
        while (rst_hold > 0) run_cycle();

        // drain
        rand_en = 1'b0; cr_mode = 0;
        repeat (100) run_cycle();

        // video held continuously while a CPU read waits
        while (cyc % 16 != 2) run_cycle();
        vid_cont = 1'b1;
        a_pend[P_CPU] = 1'b1; a_addr[P_CPU] = AW'($urandom); cpu_kind = 0;
        cnt_cpu_ack = 0;
        repeat (160) run_cycle();
`ifdef ARB_STARVE_EN
        check_eq("starve_cpu_acks", 32'(cnt_cpu_ack), 32'd1);
`else
        check_eq("starve_cpu_acks", 32'(cnt_cpu_ack), 32'd0);
`endif
        vid_cont = 1'b0;
        repeat (60) run_cycle();

        // boot write stream of four bytes
        while (cyc % 16 != 2) run_cycle();
        bs_left = 4; bs_addr = 23'h7FC000; cnt_boot_ack = 0;
        repeat (80) run_cycle();
        check_eq("boot_acks", 32'(cnt_boot_ack), 32'd4);
        check_eq("boot_span", 32'(boot_last - boot_first), 32'd48);
        check_eq("boot_last_addr", 32'(sd_addr), 32'h007F_C003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
